spi_ip_master: RTL and testbench
================================

# spi_ip_master

SPI master engine: serialises one DATA_W-bit word onto mosi_o while capturing miso_i. It supports all four SPI modes (CPOL/CPHA) and has a programmable SCLK rate. It sits behind a register/bus front-end, which supplies data and configuration and issues a start pulse. The front-end then waits for a done tick. Chip-select generation is external to this block.

## Interface
- DATA_W, default 8: transfer word width.
- DVSR_W, default 16: divisor width.
- clk_i  in  1  system clock; everything in this block is on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- din_i  in  DATA_W  word to transmit; latched at start.
- dvsr_i  in  DVSR_W  half-period divisor; one SCLK half-period = dvsr_i+1 clk_i cycles; latched at start.
- start_i  in  1  begin transfer; honoured only while ready_o=1.
- cpol_i  in  1  SCLK idle level; latched at start.
- cpha_i  in  1  clock phase; latched at start.
- dout_o  out  DATA_W  received word; holds its value until the next transfer shifts in.
- spi_done_tick_o  out  1  one-cycle pulse marking the end of a transfer.
- ready_o  out  1  high when idle, i.e. a start will be accepted.
- sclk_o  out  1  SPI serial clock.
- miso_i  in  1  serial data in.
- mosi_o  out  1  serial data out, MSB first by default.

## Operation
- FSM states: IDLE, CPHA_DELAY, P0, P1.
- IDLE
  - ready_o=1; sclk_o follows the latched CPOL.
  - On start_i: load shift-out register with din_i; clear bit counter n and phase counter c; latch cpol_i, cpha_i and dvsr_i.
  - Next state is CPHA_DELAY if cpha_i=1, else P0.
- CPHA_DELAY: counts c to dvsr, then clears c and goes to P0.
- P0
  - Counts c to dvsr.
  - On the terminal count: shift miso_i into the shift-in register (LSB end), clear c, go to P1.
- P1
  - Counts c to dvsr.
  - On the terminal count with n=DATA_W-1: assert spi_done_tick_o for that cycle and return to IDLE.
  - On the terminal count otherwise: shift the shift-out register left, n++, clear c, go to P0.
- Internal clock pclk = (P1 & ~cpha) | (P0 & cpha).
- sclk_o is registered: it is cpol ^ pclk, delayed one clk_i cycle.
- mosi_o = shift-out register MSB. dout_o = shift-in register.
- start_i outside IDLE is ignored. Changes to the config inputs mid-transfer have no effect.
- Reset values: FSM in IDLE, ready_o=1, spi_done_tick_o=0, dout_o=0, mosi_o=0, sclk_o=0, latched cpol/cpha=0, dvsr=0.
- Reset asserted mid-transfer aborts the transfer immediately and produces no done tick.

## Timing
- Start-to-first-phase latency: 1 cycle.
- cpha=0: the transfer occupies 2·DATA_W·(dvsr+1) cycles in P0/P1.
- cpha=1: add (dvsr+1) cycles for CPHA_DELAY.
- spi_done_tick_o coincides with the last P1 cycle; dout_o already holds the complete word during that cycle.
- ready_o rises the cycle after the done tick.
- A start asserted in that same cycle (when ready_o first reads 1) is accepted, allowing back-to-back transfers.
- dvsr=0 is legal: each half-period is 1 cycle, so SCLK = clk/2.

## Configuration
- SPI_IP_LSB_FIRST_EN
  - Defined: transmit and receive LSB first. The shift-out register shifts right and mosi_o is its bit 0; miso_i enters at the MSB end.
  - Undefined (default): MSB first, as described above.

## Structure
- Package spi_ip_pkg:
  - state enum typedef (IDLE, CPHA_DELAY, P0, P1);
  - default-width localparams for DATA_W and DVSR_W.
- One natural sub-module, spi_ip_phase_cnt.
  - Implements the c counter with clear and terminal-count (c==dvsr) output.
  - The top level holds the FSM and the shift registers.

## Test plan
- Reset, then idle: ready_o=1, spi_done_tick_o=0, dout_o=0; sclk_o equals cpol_i one cycle after reset release.
- Mode 0 loopback (miso_i tied to mosi_o), dvsr=4, din=0xA5:
  - done tick 80 cycles after the start edge, dout_o=0xA5;
  - sclk_o pulses 8 times with period 10 cycles.
- Mode 3 (cpol=1, cpha=1), dvsr=1, din=0x3C, miso driven 0xC3 by a slave model sampling on the SCLK edges per the mode table:
  - dout_o=0xC3;
  - done tick after 2+32 cycles;
  - sclk_o idles high.
- start_i pulsed mid-transfer: ignored, and the first transfer completes unchanged. Immediate back-to-back start on the ready_o rise with din=0x00 then 0xFF: both words received correctly.
- Reset asserted mid-transfer:
  - FSM returns to IDLE, ready_o=1 next cycle, no done tick;
  - a subsequent transfer with dvsr=0 completes in 16 cycles.
- With SPI_IP_LSB_FIRST_EN defined and din=0x01: mosi_o is high in the first bit slot only; loopback dout_o=0x01.

Source files
------------

// File: rtl/spi_ip_pkg.sv
// Shared types and default widths for the SPI master engine.
package spi_ip_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DVSR_W_DEF = 16;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StCphaDelay = 2'd1,
        StP0        = 2'd2,
        StP1        = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_ip_phase_cnt.sv
// Half-period counter: counts 0..dvsr_i and wraps, flagging the terminal count.
module spi_ip_phase_cnt
    import spi_ip_pkg::*;
#(
    parameter int unsigned DVSR_W = DVSR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    output logic              tc_o
);

    logic [DVSR_W-1:0] r_c;

    assign tc_o = (r_c == dvsr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_c <= '0;
        end else if (en_i) begin
            r_c <= tc_o ? '0 : r_c + 1'b1;
        end
    end

endmodule

// File: rtl/spi_ip_master.sv
// SPI master engine, all four CPOL/CPHA modes, programmable SCLK divisor.
// Define SPI_IP_LSB_FIRST_EN to shift LSB first in both directions.
module spi_ip_master
    import spi_ip_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DVSR_W = DVSR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    input  logic              start_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              spi_done_tick_o,
    output logic              ready_o,
    output logic              sclk_o,
    input  logic              miso_i,
    output logic              mosi_o
);

    localparam int unsigned N_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_W - 1);

    spi_state_e        r_state;
    spi_state_e        w_state_d;
    logic [DATA_W-1:0] r_so;
    logic [DATA_W-1:0] r_si;
    logic [N_W-1:0]    r_n;
    logic              r_cpol;
    logic              r_cpha;
    logic [DVSR_W-1:0] r_dvsr;
    logic              r_sclk;

    logic w_tc;
    logic w_load;
    logic w_shift_in;
    logic w_shift_out;
    logic w_done;
    logic w_pclk;
    logic w_idle;

    assign w_idle = (r_state == StIdle);

    spi_ip_phase_cnt #(
        .DVSR_W (DVSR_W)
    ) u_phase_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_idle),
        .en_i   (~w_idle),
        .dvsr_i (r_dvsr),
        .tc_o   (w_tc)
    );

    always_comb begin
        w_state_d   = r_state;
        w_load      = 1'b0;
        w_shift_in  = 1'b0;
        w_shift_out = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_load    = 1'b1;
                    w_state_d = cpha_i ? StCphaDelay : StP0;
                end
            end
            StCphaDelay: begin
                if (w_tc) w_state_d = StP0;
            end
            StP0: begin
                if (w_tc) begin
                    w_shift_in = 1'b1;
                    w_state_d  = StP1;
                end
            end
            StP1: begin
                if (w_tc) begin
                    if (r_n == N_LAST) begin
                        w_done    = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_shift_out = 1'b1;
                        w_state_d   = StP0;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Internal phase clock before CPOL inversion; CPHA picks which half is high.
    assign w_pclk = ((r_state == StP1) & ~r_cpha) | ((r_state == StP0) & r_cpha);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_so    <= '0;
            r_si    <= '0;
            r_n     <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_dvsr  <= '0;
            r_sclk  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_sclk  <= r_cpol ^ w_pclk;
            if (w_load) begin
                r_so   <= din_i;
                r_n    <= '0;
                r_cpol <= cpol_i;
                r_cpha <= cpha_i;
                r_dvsr <= dvsr_i;
            end
            if (w_shift_in) begin
`ifdef SPI_IP_LSB_FIRST_EN
                r_si <= {miso_i, r_si[DATA_W-1:1]};
`else
                r_si <= {r_si[DATA_W-2:0], miso_i};
`endif
            end
            if (w_shift_out) begin
`ifdef SPI_IP_LSB_FIRST_EN
                r_so <= {1'b0, r_so[DATA_W-1:1]};
`else
                r_so <= {r_so[DATA_W-2:0], 1'b0};
`endif
                r_n  <= r_n + 1'b1;
            end
        end
    end

`ifdef SPI_IP_LSB_FIRST_EN
    assign mosi_o = r_so[0];
`else
    assign mosi_o = r_so[DATA_W-1];
`endif

    assign dout_o          = r_si;
    assign spi_done_tick_o = w_done;
    assign ready_o         = w_idle;
    assign sclk_o          = r_sclk;

endmodule

// File: tb/tb_spi_ip_master.sv
// Scoreboard bench for spi_ip_master; honours SPI_IP_LSB_FIRST_EN for bit-order expectations.
module tb_spi_ip_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic [15:0] dvsr;
    logic        start;
    logic        cpol;
    logic        cpha;
    logic [7:0]  dout;
    logic        done;
    logic        ready;
    logic        sclk;
    logic        miso;
    logic        mosi;

    logic        loop_en;
    logic        slave_en;
    logic        slave_miso;
    logic [7:0]  slave_sr;

    assign miso = loop_en ? mosi : slave_miso;

    spi_ip_master u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .din_i           (din),
        .dvsr_i          (dvsr),
        .start_i         (start),
        .cpol_i          (cpol),
        .cpha_i          (cpha),
        .dout_o          (dout),
        .spi_done_tick_o (done),
        .ready_o         (ready),
        .sclk_o          (sclk),
        .miso_i          (miso),
        .mosi_o          (mosi)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  dout;
        int unsigned start_cyc;
        int unsigned len;
        bit          chk_slots;
        logic [7:0]  slots;
        int unsigned span;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Order in which bits of a word appear on the wire, first bit at the MSB end.
    function automatic logic [7:0] wire_order(input logic [7:0] v);
`ifdef SPI_IP_LSB_FIRST_EN
        return rev8(v);
`else
        return v;
`endif
    endfunction

    // Mode-3 slave: presents the next bit on each SCLK leading (falling) edge.
    always @(negedge sclk) begin
        if (slave_en) begin
            slave_miso = slave_sr[7];
            slave_sr   = {slave_sr[6:0], 1'b0};
        end
    end

    // Monitor: records SCLK rising edges / MOSI slots and scores each done tick.
    logic        prev_sclk;
    logic [7:0]  slot_cap;
    int unsigned slot_n;
    int unsigned first_rise;
    int unsigned last_rise;
    bit          done_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (start === 1'b1 && ready === 1'b1) begin
            slot_n   = 0;
            slot_cap = 8'h00;
        end
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            slot_cap = {slot_cap[6:0], mosi};
            if (slot_n == 0) first_rise = cyc;
            last_rise = cyc;
            slot_n++;
        end
        prev_sclk = sclk;
        if (done_prev) begin
            check("ready_after_done", {31'd0, ready}, 32'd1);
            done_prev = 1'b0;
        end
        if (done === 1'b1) begin
            done_prev = 1'b1;
            check("ready_low_on_done", {31'd0, ready}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done tick, expected none (cyc %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("dout", {24'd0, dout}, {24'd0, e.dout});
                check("latency", cyc - e.start_cyc + 1, e.len);
                if (e.chk_slots) begin
                    check("mosi_slots", {24'd0, slot_cap}, {24'd0, e.slots});
                    check("sclk_pulses", slot_n, 8);
                    check("sclk_span", last_rise - first_rise, e.span);
                end
            end
        end
    end

    // Called in the posedge+1 phase; returns in the same phase.
    task automatic do_start(input logic [7:0] d, input logic [15:0] dv, input logic pol,
                            input logic pha, input bit lp, input bit chk,
                            input logic [7:0] exp_d, output int unsigned sc);
        exp_t e;
        int   i = 0;
        while (ready !== 1'b1 && i < 2000) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b, expected 1", ready);
        end
        din     = d;
        dvsr    = dv;
        cpol    = pol;
        cpha    = pha;
        loop_en = lp;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        sc          = cyc;
        e.dout      = exp_d;
        e.start_cyc = sc;
        e.len       = 16 * (dv + 1) + (pha ? dv + 1 : 0);
        e.chk_slots = chk;
        e.slots     = wire_order(d);
        e.span      = 14 * (dv + 1);
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int i = 0;
        while (sb.size() != 0 && i < 3000) begin
            @(posedge clk);
            #1;
            i++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending transfers, expected 0", name, sb.size());
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int unsigned sc1;
        int unsigned sc2;
        rst        = 1'b1;
        din        = 8'h00;
        dvsr       = 16'd0;
        start      = 1'b0;
        cpol       = 1'b0;
        cpha       = 1'b0;
        loop_en    = 1'b1;
        slave_en   = 1'b0;
        slave_miso = 1'b0;
        slave_sr   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_sclk", {31'd0, sclk}, {31'd0, cpol});

        // Mode 0 loopback, dvsr=4
        do_start(8'hA5, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, sc1);
        drain("mode0");
        idle_cycles(3);

        // Start pulsed mid-transfer with different config must be ignored
        do_start(8'h3A, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3A, sc1);
        idle_cycles(15);
        din   = 8'hFF;
        dvsr  = 16'd0;
        cpol  = 1'b1;
        cpha  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cpol  = 1'b0;
        cpha  = 1'b0;
        drain("mid_start");

        // Back-to-back on the ready rise
        do_start(8'h00, 16'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, sc1);
        do_start(8'hFF, 16'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, sc2);
        check("b2b_gap", sc2 - sc1, 32'd33);
        drain("b2b");
        idle_cycles(3);

        // Bit-order slot check
        do_start(8'h01, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, sc1);
        drain("bit_order");
        idle_cycles(3);

        // Reset mid-transfer aborts with no done tick
        do_start(8'h77, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, sc1);
        idle_cycles(20);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_dout", {24'd0, dout}, 32'd0);
        check("abort_sclk", {31'd0, sclk}, 32'd0);
        idle_cycles(120);
        do_start(8'h5A, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, sc1);
        drain("dvsr0");
        idle_cycles(3);

        // Mode 3 against the slave model
        slave_sr = 8'hC3;
        slave_en = 1'b1;
        do_start(8'h3C, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, wire_order(8'hC3), sc1);
        drain("mode3");
        idle_cycles(4);
        check("mode3_sclk_idle", {31'd0, sclk}, 32'd1);
        slave_en = 1'b0;

        idle_cycles(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
